// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register
// and a running count of instructions delivered to decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    typedef enum logic {
        FETCH  = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    if_id_t      ifid_q, ifid_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    // The two low target bits are architecturally ignored.
    logic        unused_target_lsbs;
    assign unused_target_lsbs = ^RedirectTarget[1:0];

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = {RedirectTarget[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ifid_d  = ifid_q;
        priority case (1'b1)
            Reset: begin
                state_d        = FETCH;
                pc_d           = PC_INIT;
                count_d        = 32'd0;
                ifid_d.instr   = NOP_WORD;
                ifid_d.pcplus4 = 32'd0;
                ifid_d.valid   = 1'b0;
            end
            Redirect: begin
                state_d      = BUBBLE;
                pc_d         = target;
                ifid_d.instr = NOP_WORD;
                ifid_d.valid = 1'b0;
            end
            Stall: begin
                state_d = state_q;
            end
            default: begin
                state_d        = FETCH;
                pc_d           = pc_plus4;
                count_d        = count_q + 32'd1;
                ifid_d.instr   = Instruction;
                ifid_d.pcplus4 = pc_plus4;
                ifid_d.valid   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        count_q <= count_d;
        ifid_q  <= ifid_d;
    end

    assign Address          = pc_q;
    assign IFID_Instruction = ifid_q.instr;
    assign IFID_PCPlus4     = ifid_q.pcplus4;
    assign IFID_Valid       = ifid_q.valid;
    assign FetchCount       = count_q;

endmodule
